// File: rtl/hilo_muldiv_sequencer_if.sv
// HI/LO multiply sequencer port bundle.
// Request/operand inputs from EX and ID; Busy/Stall/Done/HI/LO back out.
interface hilo_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       OpSel;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             ReadHiLo;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, OpSel, OperandA, OperandB, ReadHiLo,
    input  Busy, Stall, Done, HI, LO
  );

  modport slave (
    input  Start, OpSel, OperandA, OperandB, ReadHiLo,
    output Busy, Stall, Done, HI, LO
  );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative shift-add multiplier that owns HI/LO (mult/multu/madd/msub/mthi/mtlo).
// Ports: Clk, Rst (async, active high), bus = slave side of the sequencer interface.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  hilo_muldiv_sequencer_if.slave bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic             sign_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    hilo_d;

  // Negating the most negative value yields 2^(W-1), which is the
  // correct magnitude once treated as unsigned.
  always_comb begin
    signed_op = (bus.OpSel != OP_MULTU);
    abs_a = bus.OperandA;
    abs_b = bus.OperandB;
    if (signed_op && bus.OperandA[WIDTH-1])
      abs_a = -bus.OperandA;
    if (signed_op && bus.OperandB[WIDTH-1])
      abs_b = -bus.OperandB;
  end

  always_comb begin
    prod = sign_q ? -acc_q : acc_q;
    unique case (op_q)
      OP_MADD: hilo_d = {hi_q, lo_q} + prod;
      OP_MSUB: hilo_d = {hi_q, lo_q} - prod;
      default: hilo_d = prod;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            unique case (bus.OpSel)
              OP_MTHI: hi_q <= bus.OperandA;
              OP_MTLO: lo_q <= bus.OperandA;
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                op_q     <= bus.OpSel;
                sign_q   <= signed_op &
                            (bus.OperandA[WIDTH-1] ^
                             bus.OperandB[WIDTH-1]);
                mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                mplier_q <= abs_b;
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (mplier_q[0])
            acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1))
            state_q <= FIN;
        end
        FIN: begin
          {hi_q, lo_q} <= hilo_d;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy  = (state_q != IDLE);
  assign bus.Stall = bus.Busy & (bus.Start | bus.ReadHiLo);
  assign bus.Done  = done_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for the HI/LO multiply sequencer.
// Vector table for single ops plus hand sequences for stall, reset, back-to-back.
module tb_hilo_muldiv_sequencer;

  localparam int W = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  hilo_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present an op for one edge, then wait (bounded) for Done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    bus.Start    = 1'b1;
    bus.OpSel    = op;
    bus.OperandA = a;
    bus.OperandB = b;
    @(posedge Clk);
    #1;
    bus.Start    = 1'b0;
    bus.OperandA = 32'h5A5A_5A5A;
    bus.OperandB = 32'hA5A5_A5A5;
    lat = 1;
    if (op[2]) return;
    while (!bus.Done && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad;
    logic [31:0] hold_hi;

    tbl[0] = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005,
               32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h0000_0001};
    tbl[3] = '{3'b101, 32'h0000_000A, 32'h0,
               32'h0000_0000, 32'h0000_000A};
    tbl[4] = '{3'b010, 32'h0000_0004, 32'h0000_0005,
               32'h0000_0000, 32'h0000_001E};
    tbl[5] = '{3'b011, 32'h0000_0001, 32'h0000_001F,
               32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[6] = '{3'b000, 32'h8000_0000, 32'h0000_0002,
               32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7] = '{3'b000, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000};
    tbl[8] = '{3'b100, 32'h1234_5678, 32'h0,
               32'h1234_5678, 32'h0000_0000};
    tbl[9] = '{3'b110, 32'hDEAD_BEEF, 32'h1,
               32'h1234_5678, 32'h0000_0000};

    bus.Start    = 1'b0;
    bus.OpSel    = 3'b000;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.ReadHiLo = 1'b0;

    #23;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      if (tbl[i].op[2]) begin
        chk($sformatf("v%0d_busy", i), 64'(bus.Busy), 64'd0);
        chk($sformatf("v%0d_done", i), 64'(bus.Done), 64'd0);
      end else begin
        chk($sformatf("v%0d_lat", i), 64'(lat), 64'd34);
      end
      chk($sformatf("v%0d_hilo", i), {bus.HI, bus.LO},
          {tbl[i].hi, tbl[i].lo});
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_done1", i), 64'(bus.Done), 64'd0);
    end

    // Stall sequence: MULT 2*3 with ReadHiLo and MTHI pending from cycle 5.
    hold_hi = bus.HI;
    bus.Start    = 1'b1;
    bus.OpSel    = 3'b000;
    bus.OperandA = 32'd2;
    bus.OperandB = 32'd3;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    chk("stl_busy", 64'(bus.Busy), 64'd1);
    repeat (4) begin
      @(posedge Clk);
      #1;
    end
    bus.Start    = 1'b1;
    bus.OpSel    = 3'b100;
    bus.OperandA = 32'hDEAD_0001;
    bus.ReadHiLo = 1'b1;
    bad = 0;
    lat = 0;
    while (!bus.Done && lat < 100) begin
      #1;
      if (!bus.Stall || bus.HI !== hold_hi) bad++;
      @(posedge Clk);
      #1;
      lat++;
    end
    chk("stl_cycles", 64'(bad), 64'd0);
    chk("stl_done", 64'(bus.Done), 64'd1);
    chk("stl_nostall", 64'(bus.Stall), 64'd0);
    chk("stl_hilo", {bus.HI, bus.LO}, {32'h0, 32'h6});
    @(posedge Clk);
    #1;
    bus.Start    = 1'b0;
    bus.ReadHiLo = 1'b0;
    chk("stl_mthi", 64'(bus.HI), 64'hDEAD_0001);

    // Reset abort mid-multiply.
    bus.Start    = 1'b1;
    bus.OpSel    = 3'b000;
    bus.OperandA = 32'd7;
    bus.OperandB = 32'd9;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    repeat (9) begin
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;
    #1;
    chk("rab_busy", 64'(bus.Busy), 64'd0);
    chk("rab_hilo", {bus.HI, bus.LO}, 64'd0);
    #5;
    Rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (bus.Done || bus.Busy) bad++;
    end
    chk("rab_nodone", 64'(bad), 64'd0);
    run_op(3'b001, 32'd7, 32'd9, lat);
    chk("rab_lat", 64'(lat), 64'd34);
    chk("rab_hilo2", {bus.HI, bus.LO}, 64'h3F);

    // Back-to-back: new MULTU presented in the Done cycle of a MULT.
    run_op(3'b000, 32'hFFFF_FFFF, 32'd2, lat);
    chk("b2b_hilo1", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.Start    = 1'b1;
    bus.OpSel    = 3'b001;
    bus.OperandA = 32'd2;
    bus.OperandB = 32'd3;
    #1;
    chk("b2b_stall", 64'(bus.Stall), 64'd0);
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    chk("b2b_busy", 64'(bus.Busy), 64'd1);
    lat = 1;
    while (!bus.Done && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_hilo2", {bus.HI, bus.LO}, 64'h6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
